// File: rtl/seq_div_pkg.sv
// Shared constants for the sequential restoring divider: FSM encoding,
// default operand width and the step-counter sizing helper.
package seq_div_pkg;

    localparam int SEQ_DIV_WIDTH = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Smallest counter width able to hold the value w itself.
    function automatic int cnt_bits(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/seq_div_borrow_sub.sv
// Ripple-borrow subtractor a - b, one full-subtractor cell per bit.
// Latency: combinational, no registers.
// Backpressure: none, pure datapath with no handshake.
module borrow_sub #(
    parameter int W = 9
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         borrow_out
);

    logic [W:0] brw;

    assign brw[0] = 1'b0;

    for (genvar i = 0; i < W; i++) begin : g_cell
        assign diff[i]  = a[i] ^ b[i] ^ brw[i];
        // Borrow out is majority(~a, b, borrow_in).
        assign brw[i+1] = (~a[i] & b[i]) | (~a[i] & brw[i]) | (b[i] & brw[i]);
    end

    assign borrow_out = brw[W];

endmodule

// File: rtl/seq_div.sv
// Unsigned sequential restoring divider, one quotient bit per RUN cycle.
// Latency: done is sampled high WIDTH+1 edges after the start edge (1 edge for divisor 0).
// Backpressure: start is only honoured in IDLE; requests while busy are dropped.
module seq_div
    import seq_div_pkg::*;
#(
    parameter int WIDTH = SEQ_DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CW = cnt_bits(WIDTH);

    logic [1:0]       state;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] prem;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial_diff;
    logic             trial_borrow;
    logic [WIDTH-1:0] prem_nxt;
    logic [WIDTH-1:0] dvd_nxt;
    logic             last_step;
    logic             unused_diff_msb;

    // The dividend register doubles as the quotient accumulator: its MSB
    // feeds the partial remainder while quotient bits enter at the LSB.
    assign shifted = {prem, dvd_q[WIDTH-1]};

    borrow_sub #(
        .W (WIDTH + 1)
    ) u_sub (
        .a          (shifted),
        .b          ({1'b0, dvs_q}),
        .diff       (trial_diff),
        .borrow_out (trial_borrow)
    );

    // A kept difference is always below the divisor, so its MSB is zero.
    assign unused_diff_msb = trial_diff[WIDTH];
    assign prem_nxt  = trial_borrow ? shifted[WIDTH-1:0] : trial_diff[WIDTH-1:0];
    assign dvd_nxt   = {dvd_q[WIDTH-2:0], ~trial_borrow};
    assign last_step = (cnt == CW'(WIDTH - 1));

    assign busy = (state == ST_RUN) || (state == ST_DONE);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            dvd_q     <= '0;
            dvs_q     <= '0;
            prem      <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            div_zero  <= 1'b1;
                            quotient  <= '1;
                            remainder <= dividend;
                            state     <= ST_DONE;
                        end else begin
                            dvd_q    <= dividend;
                            dvs_q    <= divisor;
                            prem     <= '0;
                            cnt      <= '0;
                            div_zero <= 1'b0;
                            state    <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    dvd_q <= dvd_nxt;
                    prem  <= prem_nxt;
                    cnt   <= cnt + CW'(1);
                    if (last_step) begin
                        quotient  <= dvd_nxt;
                        remainder <= prem_nxt;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div.sv
// Directed and swept checks of seq_div at the package default width.
module tb_seq_div;
    import seq_div_pkg::*;

    localparam int W = SEQ_DIV_WIDTH;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_zero;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_div #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero)
    );

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts negedges after the start edge until done is seen (bounded).
    task automatic wait_done(input int already, output int lat, output bit tmo);
        lat = already;
        tmo = 1'b0;
        forever begin
            @(negedge clk);
            lat++;
            if (done) break;
            if (lat >= 40) begin
                tmo = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({quotient, remainder, busy, done, div_zero} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got q=%0d r=%0d busy=%b done=%b dz=%b, want all 0",
                     quotient, remainder, busy, done, div_zero);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat; bit tmo;
        start_op(8'd100, 8'd7);
        dividend = 8'd33;
        divisor  = 8'd3;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++; $display("FAIL basic_busy: got %b, want 1", busy);
        end
        wait_done(0, lat, tmo);
        n_cmp++;
        if (tmo || lat != 9 || quotient !== 8'd14 || remainder !== 8'd2 || div_zero !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL basic_100_7: got lat=%0d q=%0d r=%0d dz=%b busy=%b, want lat=9 q=14 r=2 dz=0 busy=1",
                     lat, quotient, remainder, div_zero, busy);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL done_one_cycle: got done=%b busy=%b, want 0 0", done, busy);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (quotient !== 8'd14 || remainder !== 8'd2) begin
            n_err++; $display("FAIL result_hold: got q=%0d r=%0d, want 14 2", quotient, remainder);
        end
    endtask

    task automatic test_back_to_back();
        int lat; bit tmo;
        start_op(8'd3, 8'd10);
        wait_done(0, lat, tmo);
        n_cmp++;
        if (tmo || lat != 9 || quotient !== 8'd0 || remainder !== 8'd3) begin
            n_err++; $display("FAIL b2b_3_10: got lat=%0d q=%0d r=%0d, want lat=9 q=0 r=3", lat, quotient, remainder);
        end
        start_op(8'd255, 8'd1);
        wait_done(0, lat, tmo);
        n_cmp++;
        if (tmo || lat != 9 || quotient !== 8'd255 || remainder !== 8'd0) begin
            n_err++; $display("FAIL b2b_255_1: got lat=%0d q=%0d r=%0d, want lat=9 q=255 r=0", lat, quotient, remainder);
        end
    endtask

    task automatic test_div_zero();
        int lat; bit tmo;
        start_op(8'd5, 8'd0);
        wait_done(0, lat, tmo);
        n_cmp++;
        if (tmo || lat != 1 || div_zero !== 1'b1 || quotient !== 8'd255 || remainder !== 8'd5) begin
            n_err++;
            $display("FAIL div_zero_5_0: got lat=%0d dz=%b q=%0d r=%0d, want lat=1 dz=1 q=255 r=5",
                     lat, div_zero, quotient, remainder);
        end
        start_op(8'd100, 8'd7);
        n_cmp++;
        if (div_zero !== 1'b0) begin
            n_err++; $display("FAIL div_zero_clear: got %b, want 0", div_zero);
        end
        wait_done(0, lat, tmo);
        n_cmp++;
        if (tmo || lat != 9 || quotient !== 8'd14 || remainder !== 8'd2) begin
            n_err++; $display("FAIL after_div_zero: got lat=%0d q=%0d r=%0d, want lat=9 q=14 r=2", lat, quotient, remainder);
        end
    endtask

    task automatic test_busy_ignore();
        int lat; bit tmo;
        start_op(8'd200, 8'd9);
        repeat (3) @(negedge clk);
        @(negedge clk);
        start = 1'b1; dividend = 8'd1; divisor = 8'd1;
        @(negedge clk);
        start = 1'b0;
        wait_done(5, lat, tmo);
        n_cmp++;
        if (tmo || lat != 9 || quotient !== 8'd22 || remainder !== 8'd2) begin
            n_err++; $display("FAIL busy_ignore_run: got lat=%0d q=%0d r=%0d, want lat=9 q=22 r=2", lat, quotient, remainder);
        end
        // A divide-by-zero request offered during DONE must also be dropped.
        start = 1'b1; dividend = 8'd7; divisor = 8'd0;
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || div_zero !== 1'b0 || quotient !== 8'd22 || remainder !== 8'd2) begin
            n_err++;
            $display("FAIL busy_ignore_done: got busy=%b dz=%b q=%0d r=%0d, want 0 0 22 2",
                     busy, div_zero, quotient, remainder);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat; bit tmo; bit saw_done;
        start_op(8'd200, 8'd9);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({quotient, remainder, busy, done, div_zero} !== '0) begin
            n_err++;
            $display("FAIL reset_mid_run: got q=%0d r=%0d busy=%b done=%b dz=%b, want all 0",
                     quotient, remainder, busy, done, div_zero);
        end
        saw_done = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        n_cmp++;
        if (saw_done !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL abort_no_done: got done_seen=%b busy=%b, want 0 0", saw_done, busy);
        end
        start_op(8'd50, 8'd5);
        wait_done(0, lat, tmo);
        n_cmp++;
        if (tmo || lat != 9 || quotient !== 8'd10 || remainder !== 8'd0) begin
            n_err++; $display("FAIL post_reset_50_5: got lat=%0d q=%0d r=%0d, want lat=9 q=10 r=0", lat, quotient, remainder);
        end
    endtask

    task automatic test_edges();
        logic [W-1:0] va [5] = '{8'd255, 8'd0,  8'd254, 8'd128, 8'd0};
        logic [W-1:0] vb [5] = '{8'd255, 8'd1,  8'd255, 8'd2,   8'd0};
        logic [W-1:0] vq [5] = '{8'd1,   8'd0,  8'd0,   8'd64,  8'd255};
        logic [W-1:0] vr [5] = '{8'd0,   8'd0,  8'd254, 8'd0,   8'd0};
        int           vl [5] = '{9, 9, 9, 9, 1};
        int lat; bit tmo;
        for (int i = 0; i < 5; i++) begin
            start_op(va[i], vb[i]);
            wait_done(0, lat, tmo);
            n_cmp++;
            if (tmo || lat != vl[i] || quotient !== vq[i] || remainder !== vr[i]) begin
                n_err++;
                $display("FAIL edge_%0d_%0d: got lat=%0d q=%0d r=%0d, want lat=%0d q=%0d r=%0d",
                         va[i], vb[i], lat, quotient, remainder, vl[i], vq[i], vr[i]);
            end
        end
    endtask

    task automatic test_random_sweep();
        logic [W-1:0] a, b, eq, er;
        logic         edz;
        int lat, elat; bit tmo;
        for (int i = 0; i < 2000; i++) begin
            a = W'($urandom_range(0, 255));
            b = W'($urandom_range(0, 255));
            if (b == '0) begin
                eq = '1; er = a; edz = 1'b1; elat = 1;
            end else begin
                eq = a / b; er = a % b; edz = 1'b0; elat = 9;
            end
            start_op(a, b);
            wait_done(0, lat, tmo);
            n_cmp++;
            if (tmo || lat != elat || quotient !== eq || remainder !== er || div_zero !== edz) begin
                n_err++;
                $display("FAIL sweep_%0d_%0d: got lat=%0d q=%0d r=%0d dz=%b, want lat=%0d q=%0d r=%0d dz=%b",
                         a, b, lat, quotient, remainder, div_zero, elat, eq, er, edz);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_div_zero();
        test_busy_ignore();
        test_reset_mid_run();
        test_edges();
        test_random_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
